mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide engine that produces the Hi/Lo write stream for the HiLo register file. It drives that file's WriteHiData, WriteLoData, WriteEn, Madd and Msub inputs.
- Sits in the EX stage beside the ALU. The control unit issues one operation with Start, holds issue while Busy, and the result lands in Hi/Lo through a single-cycle write pulse.
- Covers MULT, MULTU, DIV, DIVU, MADD and MSUB.

Parameters:
- DATA_WIDTH, 32, operand width. Hi and Lo are each DATA_WIDTH bits, and the compute phase lasts DATA_WIDTH cycles.

Ports:
- Clk  input  1  clock, rising-edge active
- Rst  input  1  synchronous active-high reset
- Start  input  1  request new operation; sampled only in IDLE
- Op  input  3  operation code (package encodings)
- OperandA  input  DATA_WIDTH  rs value (multiplicand / dividend)
- OperandB  input  DATA_WIDTH  rt value (multiplier / divisor)
- Busy  output  1  high from the cycle after accept through the WRITE cycle
- Done  output  1  one-cycle pulse, coincident with the write pulse
- WriteHiData  output  DATA_WIDTH  Hi result: product[63:32] or remainder
- WriteLoData  output  DATA_WIDTH  Lo result: product[31:0] or quotient
- WriteEn  output  1  one-cycle pulse for MULT, MULTU, DIV, DIVU
- Madd  output  1  one-cycle pulse for MADD
- Msub  output  1  one-cycle pulse for MSUB

Behaviour:
- Clock and reset: one clock Clk. Rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; internal registers cleared.
- State machine, IDLE -> CALC -> FIX -> WRITE -> IDLE:
  - IDLE: when Start=1 at edge t, latch Op and both operands. For signed ops, convert operands to magnitudes and record the sign flags. Go to CALC.
  - CALC: runs for DATA_WIDTH cycles (t+1 .. t+32).
    - Multiply: shift-add, one multiplier bit per cycle, 2*DATA_WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - FIX (t+33): apply the sign corrections.
    - Product is negated if the operand signs differ (MULT, MADD, MSUB).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - WRITE (t+34): WriteHiData/WriteLoData are valid. Exactly one of WriteEn/Madd/Msub is high, together with Done, for this single cycle. Return to IDLE.
- Latency: 34 cycles from the accept edge to the write pulse. The next Start is accepted on the WRITE cycle's following edge, at the earliest.
- Data outputs hold their last result after WRITE, until the next WRITE. Pulse outputs are 0 outside WRITE.
- MADD/MSUB: output the signed 64-bit product split into Hi/Lo. The accumulate itself happens in the HiLo register file; this block never reads Hi/Lo.
- MULTU, DIVU: operands are treated as unsigned, with no sign fix.
- Divide by zero (DIV or DIVU): Hi = dividend unmodified, Lo = all ones. Latency is unchanged (34 cycles).
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0.
- Start while Busy: ignored. No queuing, and latched operands are unaffected.
- Undefined Op code at Start: ignored; stays in IDLE.
- Rst mid-operation: returns to IDLE on the next edge, with no write pulse, Busy=0 and all outputs cleared.
- Start together with Rst: Rst wins.

Decomposition:
- Shared package mdu_pkg holds:
  - Op encodings: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MADD=4, OP_MSUB=5.
  - State encodings: IDLE, CALC, FIX, WRITE.
  - Constant ITER_CNT_W = $clog2(DATA_WIDTH)+1.
- One natural sub-module, mdu_datapath: accumulator, shift/subtract step and sign-fix logic. The parent holds the FSM, the iteration counter and the output pulses.

Test Plan:
- MULT -3 × 5, Start at cycle 0 -> cycle 34: WriteEn=1, Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Busy is high for cycles 1-34; WriteEn is 0 on every other cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Separately, MADD 3 × 4 -> Madd=1, WriteEn=0, Hi=0, Lo=12.
- DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Separately, DIVU 7 / 2 -> Lo=3, Hi=1.
- Division corner cases:
  - DIVU 7 / 0 -> Hi=7, Lo=0xFFFFFFFF at cycle 34.
  - DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start (MULT 9 × 9) at cycle 0, then Start (MULT 2 × 2) at cycle 5 -> a single pulse at cycle 34 with Lo=81. The second request produces no pulse.
- Start MSUB at cycle 0 with Rst=1 at cycle 10 -> Busy=0 from cycle 11, no Msub/Done pulse through cycle 40. A new Start at cycle 12 completes at cycle 46.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and sizing for the multiply/divide unit
package mdu_pkg;
  localparam int DEF_WIDTH = 32;
  function automatic int iter_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int ITER_CNT_W = iter_cnt_w(DEF_WIDTH);
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: magnitude accumulator with shift-add / restoring-divide step and sign fix
module mdu_datapath import mdu_pkg::*; #(
  parameter int W = DEF_WIDTH
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic         step,
  input  logic         fix,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic [2*W-1:0] acc, acc_step, acc_fix;
  logic [W-1:0] opnd, am, bm, new_r;
  logic [W:0] mul_sum, rs;
  logic is_mul, neg_res, neg_rem, div0, mul_op, sgn_op, sa, sb, ge;
  // operand magnitudes at load, one iteration step, and the final sign correction
  always_comb begin
    mul_op = op != OP_DIV && op != OP_DIVU;
    sgn_op = op != OP_MULTU && op != OP_DIVU;
    sa = sgn_op && a[W-1];
    sb = sgn_op && b[W-1];
    am = sa ? -a : a;
    bm = sb ? -b : b;
    mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    rs = {acc[2*W-1:W], acc[W-1]};
    ge = rs >= {1'b0, opnd};
    new_r = ge ? W'(rs - {1'b0, opnd}) : rs[W-1:0];
    acc_step = is_mul ? (acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]})
                      : {new_r, acc[W-2:0], ge};
    acc_fix = is_mul ? (neg_res ? -acc : acc)
                     : {neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W],
                        div0 ? {W{1'b1}} : neg_res ? -acc[W-1:0] : acc[W-1:0]};
  end
  // multiplier or dividend sits in the low half; the other operand stays in opnd
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc <= '0;
      opnd <= '0;
      is_mul <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0 <= 1'b0;
    end else if (load) begin
      acc <= {{W{1'b0}}, mul_op ? bm : am};
      opnd <= mul_op ? am : bm;
      is_mul <= mul_op;
      neg_res <= sa ^ sb;
      neg_rem <= sa;
      div0 <= b == '0;
    end else if (step) begin
      acc <= acc_step;
    end else if (fix) begin
      acc <= acc_fix;
    end
  end
  assign {hi, lo} = acc;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide engine producing the Hi/Lo write stream
module mul_div_unit import mdu_pkg::*; #(
  parameter int DATA_WIDTH = DEF_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] WriteHiData,
  output logic [DATA_WIDTH-1:0] WriteLoData,
  output logic                  WriteEn,
  output logic                  Madd,
  output logic                  Msub
);
  localparam int CW = ITER_CNT_W > iter_cnt_w(DATA_WIDTH) ? ITER_CNT_W : iter_cnt_w(DATA_WIDTH);
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [DATA_WIDTH-1:0] hi, lo;
  logic accept, last, wr;
  // accept only defined ops in IDLE; CALC lasts exactly DATA_WIDTH steps
  always_comb begin
    accept = state == IDLE && Start && Op <= OP_MSUB;
    last = cnt == CW'(DATA_WIDTH - 1);
    wr = state == WRITE;
    next_state = state == IDLE ? (accept ? CALC : IDLE)
               : state == CALC ? (last ? FIX : CALC)
               : state == FIX  ? WRITE : IDLE;
  end
  // state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else state <= next_state;
  end
  // iteration counter and the op that selects the write pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      op_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      op_q <= Op;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
    end
  end
  // registered outputs: pulses during the cycle after WRITE's edge, data held until the next write
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Busy <= 1'b0;
      Done <= 1'b0;
      WriteEn <= 1'b0;
      Madd <= 1'b0;
      Msub <= 1'b0;
      WriteHiData <= '0;
      WriteLoData <= '0;
    end else begin
      Busy <= state != IDLE;
      Done <= wr;
      WriteEn <= wr && op_q < OP_MADD;
      Madd <= wr && op_q == OP_MADD;
      Msub <= wr && op_q == OP_MSUB;
      if (wr) begin
        WriteHiData <= hi;
        WriteLoData <= lo;
      end
    end
  end
  mdu_datapath #(.W(DATA_WIDTH)) u_dp (
    .Clk(Clk),
    .Rst(Rst),
    .load(accept),
    .step(state == CALC),
    .fix(state == FIX),
    .op(Op),
    .a(OperandA),
    .b(OperandB),
    .hi(hi),
    .lo(lo)
  );
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks against an arithmetic reference model
module tb_mul_div_unit;
  import mdu_pkg::*;
  logic Clk, Rst, Start;
  logic [2:0] Op;
  logic [31:0] OperandA, OperandB, WriteHiData, WriteLoData;
  logic Busy, Done, WriteEn, Madd, Msub;
  int total, bad;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done),
    .WriteHiData(WriteHiData), .WriteLoData(WriteLoData),
    .WriteEn(WriteEn), .Madd(Madd), .Msub(Msub)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint p;
    int sa, sb;
    h = '0;
    l = '0;
    case (o)
      3'd1: {h, l} = {32'b0, a} * {32'b0, b};
      3'd0, 3'd4, 3'd5: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {h, l} = p;
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = '0;
          l = a;
        end else if (o == 3'd2) begin
          sa = a;
          sb = b;
          l = sa / sb;
          h = sa % sb;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    Op = o;
    OperandA = a;
    OperandB = b;
    Start = 1'b1;
    tick;
    chk("busy_at_accept", 64'(Busy), 64'(0));
    for (int k = 1; k <= 35; k++) begin
      Start = k < 34 ? 1'($urandom_range(0, 1)) : 1'b0;
      Op = 3'($urandom_range(0, 7));
      OperandA = $urandom;
      OperandB = $urandom;
      tick;
      chk("busy", 64'(Busy), 64'(k <= 34));
      chk("done", 64'(Done), 64'(k == 34));
      chk("write_en", 64'(WriteEn), 64'(k == 34 && o < 3'd4));
      chk("madd", 64'(Madd), 64'(k == 34 && o == 3'd4));
      chk("msub", 64'(Msub), 64'(k == 34 && o == 3'd5));
      if (k >= 34) chk("hi_lo", {WriteHiData, WriteLoData}, {eh, el});
    end
    Start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0] ro;
    total = 0;
    bad = 0;
    Rst = 1'b1;
    Start = 1'b0;
    Op = '0;
    OperandA = '0;
    OperandB = '0;
    tick;
    tick;
    chk("reset_outputs", {25'b0, Busy, Done, WriteEn, Madd, Msub, WriteHiData, WriteLoData}, 64'(0));
    Rst = 1'b0;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MADD, 32'd3, 32'd4);
    run_op(OP_MSUB, 32'hFFFF_FFF9, 32'd6);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU, 32'd7, 32'd2);
    run_op(OP_DIVU, 32'd7, 32'd0);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9);
    run_op(OP_MULT, 32'd9, 32'd9);
    Op = 3'd6;
    Start = 1'b1;
    tick;
    Op = 3'd7;
    tick;
    Start = 1'b0;
    tick;
    chk("undefined_op_idle", 64'(Busy), 64'(0));
    Rst = 1'b1;
    Start = 1'b1;
    Op = OP_MULT;
    tick;
    Rst = 1'b0;
    Start = 1'b0;
    tick;
    chk("start_with_rst", 64'(Busy), 64'(0));
    run_op(OP_MULT, 32'd12, 32'd11);
    Op = OP_MSUB;
    OperandA = 32'd1234;
    OperandB = 32'd77;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int k = 1; k <= 9; k++) tick;
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    chk("midop_rst_busy", 64'(Busy), 64'(0));
    chk("midop_rst_data", {WriteHiData, WriteLoData}, 64'(0));
    tick;
    chk("midop_rst_pulses", {59'b0, Busy, Done, WriteEn, Madd, Msub}, 64'(0));
    run_op(OP_MULT, 32'd2, 32'd2);
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      run_op(ro, ra, rb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
